flow_verdict_arbiter: RTL and testbench
=======================================

// Module: flow_verdict_arbiter
// PURPOSE
// - Collects per-flow classification verdicts from N protocol parsers (SSH, SNI/TLS, ...) that share one flow-table write port.
// - Each parser posts a {flow_id, flow_type} verdict on a 1-cycle strobe.
// - Each requester gets a 1-deep holding slot; slots are round-robin arbitrated into one registered valid/ready write port.
// - Sits between the parser bank and the flow-table updater.
// PARAMETERS
// - N_REQ      4   number of parser requesters (2..8)
// - FLOW_ID_W  8   flow id width
// - TYPE_W     3   flow type width
// - CNT_W      16  drop counter width
// PORTS
// - i_clk            in   1               clock; all logic on posedge
// - i_rst            in   1               synchronous reset, active-high
// - i_req_valid      in   N_REQ           per-parser verdict strobe (1 cycle)
// - i_req_flow_id    in   N_REQ*FLOW_ID_W packed, req k at [k*FLOW_ID_W +: FLOW_ID_W]
// - i_req_flow_type  in   N_REQ*TYPE_W    packed, req k at [k*TYPE_W +: TYPE_W]
// - o_req_busy       out  N_REQ           slot k currently holds a verdict
// - o_wr_valid       out  1               flow-table write request
// - o_wr_flow_id     out  FLOW_ID_W       write flow id
// - o_wr_flow_type   out  TYPE_W          write flow type
// - o_wr_src         out  clog2(N_REQ)    index of the requester being written
// - i_wr_ready       in   1               flow-table accepts when o_wr_valid & i_wr_ready
// - o_drop_cnt       out  CNT_W           verdicts lost to slot conflict; saturating
// BEHAVIOUR
// - Reset values: all slots EMPTY; o_req_busy=0, o_wr_valid=0, o_wr_flow_id=0, o_wr_flow_type=0, o_wr_src=0, o_drop_cnt=0; RR pointer=0.
// - Clock and reset: one clock; reset is synchronous and active-high.
// - Reset mid-operation: pending slot and output contents are discarded; the output drops o_wr_valid the cycle after i_rst.
// - Slot FSM per requester k: EMPTY -> FULL and FULL -> EMPTY.
//   - EMPTY & i_req_valid[k]: capture {id, type}; FULL next cycle.
//   - FULL & granted this cycle: EMPTY, unless i_req_valid[k] is also set this cycle.
//     In that case, capture the new verdict; it stays FULL and nothing is dropped.
//   - FULL & not granted & i_req_valid[k] & same flow_id: overwrite the type (latest verdict wins); no drop.
//   - FULL & not granted & i_req_valid[k] & different flow_id: new verdict discarded; o_drop_cnt+1, saturating at all-ones.
//   - Several requesters dropping in the same cycle: o_drop_cnt adds the number of drops, saturating.
// - Output register has two states: IDLE (o_wr_valid=0) and PEND (o_wr_valid=1).
//   - A load is allowed when IDLE, or when PEND & i_wr_ready (back-to-back, no bubble).
//   - On a load with any slot FULL: grant the first FULL slot at or after the RR pointer, wrapping N_REQ-1 -> 0.
//     The granted slot's contents and index load into o_wr_* next cycle; pointer <= grant+1 mod N_REQ.
//   - Load allowed but no slot FULL: PEND & ready -> IDLE; IDLE stays IDLE; pointer unchanged.
//   - PEND & !i_wr_ready: o_wr_* held stable; no grant; pointer unchanged.
// - Grant uses slot contents as of the start of the cycle. A same-cycle overwrite of a granted slot is therefore the recapture case above.
// - Latency: strobe at cycle t -> slot FULL at t+1 -> o_wr_valid at t+2 at earliest (output idle, no contention).
// - Throughput: one write per cycle while i_wr_ready=1 and any slot is FULL.
// - Fairness: with all slots continuously FULL, each requester is granted once every N_REQ writes.
// - flow_type is forwarded unchanged, including 0 (parser timeout / unknown).
// - o_req_busy[k] equals the slot-k FULL flag (registered).
// TESTING
// - Reset, then single req: i_req_valid=0001, id=8'h12, type=3'b100, ready=1 at t
//   -> o_wr_valid=1, id=8'h12, type=4, src=0 at t+2 only; busy[0]=1 at t+1 only.
// - All four strobe at t (ids 10..13), ready=1 -> writes src 0,1,2,3 at t+2..t+5; then o_wr_valid=0; drop_cnt=0.
// - Backpressure: ready=0 with output PEND for 5 cycles -> o_wr_* constant.
//   A second strobe on a FULL slot with the same id overwrites its type; a different id makes drop_cnt +1.
//   Raising ready then releases the writes in RR order.
// - Recapture: slot 1 FULL & granted while a new strobe (id 8'h20) arrives the same cycle
//   -> slot stays FULL with 8'h20, no drop; it is written on the next RR turn.
// - Saturation: preload o_drop_cnt to 16'hFFFE (force), cause 3 simultaneous drops -> 16'hFFFF, holds.
// - Reset asserted with 2 slots FULL and output PEND -> next cycle o_wr_valid=0, busy=0, pointer=0; a new strobe behaves as in the first test.

Source files
------------

// File: rtl/flow_verdict_arbiter.sv
// flow_verdict_arbiter
//   Collects {flow_id, flow_type} verdicts from N_REQ protocol parsers and
//   funnels them into one registered valid/ready flow-table write port.
//   Each parser owns a 1-deep holding slot. FULL slots are granted
//   round-robin into the output register.
//
// Ports
//   i_clk, i_rst       clock; synchronous active-high reset
//   i_req_valid        per-parser 1-cycle verdict strobe
//   i_req_flow_id      packed ids, requester k at [k*FLOW_ID_W +: FLOW_ID_W]
//   i_req_flow_type    packed types, requester k at [k*TYPE_W +: TYPE_W]
//   o_req_busy         slot k currently holds a verdict
//   o_wr_valid/_flow_id/_flow_type/_src  flow-table write request
//   i_wr_ready         flow-table accepts when o_wr_valid & i_wr_ready
//   o_drop_cnt         saturating count of verdicts lost to slot conflicts
module flow_verdict_arbiter #(
    parameter int  N_REQ     = 4,
    parameter int  FLOW_ID_W = 8,
    parameter int  TYPE_W    = 3,
    parameter int  CNT_W     = 16,
    localparam int SRC_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ*FLOW_ID_W-1:0] i_req_flow_id,
    input  logic [N_REQ*TYPE_W-1:0]    i_req_flow_type,
    output logic [N_REQ-1:0]           o_req_busy,
    output logic                       o_wr_valid,
    output logic [FLOW_ID_W-1:0]       o_wr_flow_id,
    output logic [TYPE_W-1:0]          o_wr_flow_type,
    output logic [SRC_W-1:0]           o_wr_src,
    input  logic                       i_wr_ready,
    output logic [CNT_W-1:0]           o_drop_cnt
);

    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;
    typedef enum logic {OUT_IDLE = 1'b0, OUT_PEND = 1'b1} out_e;

    slot_e                slot_q      [N_REQ];
    slot_e                slot_d      [N_REQ];
    logic [FLOW_ID_W-1:0] slot_id_q   [N_REQ];
    logic [FLOW_ID_W-1:0] slot_id_d   [N_REQ];
    logic [TYPE_W-1:0]    slot_type_q [N_REQ];
    logic [TYPE_W-1:0]    slot_type_d [N_REQ];

    out_e                 out_q, out_d;
    logic [FLOW_ID_W-1:0] wr_id_q, wr_id_d;
    logic [TYPE_W-1:0]    wr_type_q, wr_type_d;
    logic [SRC_W-1:0]     wr_src_q, wr_src_d;
    logic [SRC_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     drop_q, drop_d;

    logic                 load_ok;
    logic                 any_full;
    logic                 grant_en;
    logic [SRC_W-1:0]     grant_idx;
    logic [SRC_W-1:0]     grant_cand;
    logic [SRC_W:0]       n_drops;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [SRC_W:0]   b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-SRC_W){1'b0}}, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Output register may take a new entry when empty or when its current
    // entry is being accepted this cycle (no bubble between writes).
    assign load_ok  = (out_q == OUT_PEND) ? i_wr_ready : 1'b1;
    assign grant_en = load_ok & any_full;

    // Round-robin search: scan offsets from farthest to nearest so the
    // nearest FULL slot at or after the pointer is the one left standing.
    always_comb begin
        any_full   = 1'b0;
        grant_idx  = '0;
        grant_cand = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            grant_cand = SRC_W'((int'(ptr_q) + off) % N_REQ);
            if (slot_q[grant_cand] == SLOT_FULL) begin
                any_full  = 1'b1;
                grant_idx = grant_cand;
            end
        end
    end

    // Slot FSMs. A slot being drained this cycle behaves like an empty one,
    // so a same-cycle strobe is recaptured instead of dropped.
    always_comb begin
        n_drops = '0;
        for (int k = 0; k < N_REQ; k++) begin
            slot_d[k]      = slot_q[k];
            slot_id_d[k]   = slot_id_q[k];
            slot_type_d[k] = slot_type_q[k];
            if (slot_q[k] == SLOT_EMPTY || (grant_en && grant_idx == SRC_W'(k))) begin
                if (i_req_valid[k]) begin
                    slot_d[k]      = SLOT_FULL;
                    slot_id_d[k]   = i_req_flow_id[k*FLOW_ID_W +: FLOW_ID_W];
                    slot_type_d[k] = i_req_flow_type[k*TYPE_W +: TYPE_W];
                end else begin
                    slot_d[k] = SLOT_EMPTY;
                end
            end else if (i_req_valid[k]) begin
                // Same flow: latest verdict wins. Different flow: lost.
                if (i_req_flow_id[k*FLOW_ID_W +: FLOW_ID_W] == slot_id_q[k]) begin
                    slot_type_d[k] = i_req_flow_type[k*TYPE_W +: TYPE_W];
                end else begin
                    n_drops = n_drops + (SRC_W+1)'(1);
                end
            end
        end
        drop_d = sat_add(drop_q, n_drops);
    end

    // Output register FSM next state.
    always_comb begin
        out_d     = out_q;
        wr_id_d   = wr_id_q;
        wr_type_d = wr_type_q;
        wr_src_d  = wr_src_q;
        ptr_d     = ptr_q;
        if (load_ok) begin
            if (any_full) begin
                out_d     = OUT_PEND;
                wr_id_d   = slot_id_q[grant_idx];
                wr_type_d = slot_type_q[grant_idx];
                wr_src_d  = grant_idx;
                ptr_d     = (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
            end else begin
                out_d = OUT_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q     <= OUT_IDLE;
            wr_id_q   <= '0;
            wr_type_q <= '0;
            wr_src_q  <= '0;
            ptr_q     <= '0;
            drop_q    <= '0;
            for (int k = 0; k < N_REQ; k++) begin
                slot_q[k] <= SLOT_EMPTY;
            end
        end else begin
            out_q     <= out_d;
            wr_id_q   <= wr_id_d;
            wr_type_q <= wr_type_d;
            wr_src_q  <= wr_src_d;
            ptr_q     <= ptr_d;
            drop_q    <= drop_d;
            for (int k = 0; k < N_REQ; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    // Slot payload is only observed while its slot is FULL, so it needs no reset.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < N_REQ; k++) begin
            slot_id_q[k]   <= slot_id_d[k];
            slot_type_q[k] <= slot_type_d[k];
        end
    end

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            o_req_busy[k] = (slot_q[k] == SLOT_FULL);
        end
    end

    assign o_wr_valid     = (out_q == OUT_PEND);
    assign o_wr_flow_id   = wr_id_q;
    assign o_wr_flow_type = wr_type_q;
    assign o_wr_src       = wr_src_q;
    assign o_drop_cnt     = drop_q;

endmodule

// File: tb/tb_flow_verdict_arbiter.sv
// Bench for flow_verdict_arbiter: directed scenarios plus a randomized run
// against a behavioural reference model.
module tb_flow_verdict_arbiter;

    localparam int N  = 4;
    localparam int IW = 8;
    localparam int TW = 3;
    localparam int CW = 16;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*IW-1:0] req_id;
    logic [N*TW-1:0] req_type;
    logic [N-1:0]  busy;
    logic          wr_valid;
    logic [IW-1:0] wr_id;
    logic [TW-1:0] wr_type;
    logic [SW-1:0] wr_src;
    logic          wr_ready;
    logic [CW-1:0] drop_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    bit            m_full [N];
    logic [IW-1:0] m_id   [N];
    logic [TW-1:0] m_type [N];
    bit            m_valid;
    logic [IW-1:0] m_wid;
    logic [TW-1:0] m_wtype;
    int            m_src;
    int            m_ptr;
    int            m_drop;

    always #5 clk = ~clk;

    flow_verdict_arbiter #(
        .N_REQ(N), .FLOW_ID_W(IW), .TYPE_W(TW), .CNT_W(CW)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_req_valid(req_valid),
        .i_req_flow_id(req_id),
        .i_req_flow_type(req_type),
        .o_req_busy(busy),
        .o_wr_valid(wr_valid),
        .o_wr_flow_id(wr_id),
        .o_wr_flow_type(wr_type),
        .o_wr_src(wr_src),
        .i_wr_ready(wr_ready),
        .o_drop_cnt(drop_cnt)
    );

    function automatic logic [13:0] wr_word();
        return {wr_valid, wr_id, wr_type, wr_src};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [IW-1:0] id, input logic [TW-1:0] ty);
        req_valid[k]         = 1'b1;
        req_id[k*IW +: IW]   = id;
        req_type[k*TW +: TW] = ty;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (wr_word() !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_wr got %h want 0000", wr_word());
        end
        vectors++;
        if (busy !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_busy got %b want 0000", busy);
        end
        vectors++;
        if (drop_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_drop got %h want 0000", drop_cnt);
        end
    endtask

    task automatic test_single();
        wr_ready = 1'b1;
        set_req(0, 8'h12, 3'b100);
        tick();
        req_valid = '0;
        vectors++;
        if (busy !== 4'b0001 || wr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_t1 got busy=%b valid=%b want busy=0001 valid=0", busy, wr_valid);
        end
        tick();
        vectors++;
        if (wr_word() !== {1'b1, 8'h12, 3'd4, 2'd0} || busy !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_t2 got wr=%h busy=%b want wr=%h busy=0000",
                     wr_word(), busy, {1'b1, 8'h12, 3'd4, 2'd0});
        end
        tick();
        vectors++;
        if (wr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_t3 got valid=%b want 0", wr_valid);
        end
    endtask

    task automatic test_all_four();
        logic [13:0] exp;
        do_reset();
        wr_ready = 1'b1;
        for (int k = 0; k < N; k++) set_req(k, 8'(8'h10 + k), 3'(k));
        tick();
        req_valid = '0;
        vectors++;
        if (busy !== 4'b1111 || wr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL all4_t1 got busy=%b valid=%b want busy=1111 valid=0", busy, wr_valid);
        end
        for (int i = 0; i < N; i++) begin
            tick();
            exp = {1'b1, 8'(8'h10 + i), 3'(i), 2'(i)};
            vectors++;
            if (wr_word() !== exp || busy !== 4'(4'hE << i)) begin
                miscompares++;
                $display("FAIL all4_write%0d got wr=%h busy=%b want wr=%h busy=%b",
                         i, wr_word(), busy, exp, 4'(4'hE << i));
            end
        end
        tick();
        vectors++;
        if (wr_valid !== 1'b0 || drop_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL all4_end got valid=%b drop=%h want valid=0 drop=0000", wr_valid, drop_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [13:0] hold;
        do_reset();
        wr_ready = 1'b0;
        set_req(0, 8'h30, 3'd1);
        set_req(2, 8'h32, 3'd2);
        tick();
        req_valid = '0;
        tick();
        hold = wr_word();
        vectors++;
        if (hold !== {1'b1, 8'h30, 3'd1, 2'd0} || busy !== 4'b0100) begin
            miscompares++;
            $display("FAIL bp_first got wr=%h busy=%b want wr=%h busy=0100",
                     hold, busy, {1'b1, 8'h30, 3'd1, 2'd0});
        end
        set_req(2, 8'h32, 3'd5);
        set_req(0, 8'h40, 3'd3);
        tick();
        req_valid = '0;
        vectors++;
        if (busy !== 4'b0101 || wr_word() !== hold || drop_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL bp_overwrite got wr=%h busy=%b drop=%h want wr=%h busy=0101 drop=0000",
                     wr_word(), busy, drop_cnt, hold);
        end
        set_req(2, 8'h99, 3'd7);
        tick();
        req_valid = '0;
        vectors++;
        if (drop_cnt !== 16'h1 || wr_word() !== hold) begin
            miscompares++;
            $display("FAIL bp_drop got drop=%h wr=%h want drop=0001 wr=%h", drop_cnt, wr_word(), hold);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (wr_word() !== hold) begin
                miscompares++;
                $display("FAIL bp_hold%0d got %h want %h", i, wr_word(), hold);
            end
        end
        wr_ready = 1'b1;
        tick();
        vectors++;
        if (wr_word() !== {1'b1, 8'h32, 3'd5, 2'd2}) begin
            miscompares++;
            $display("FAIL bp_release1 got %h want %h", wr_word(), {1'b1, 8'h32, 3'd5, 2'd2});
        end
        tick();
        vectors++;
        if (wr_word() !== {1'b1, 8'h40, 3'd3, 2'd0}) begin
            miscompares++;
            $display("FAIL bp_release2 got %h want %h", wr_word(), {1'b1, 8'h40, 3'd3, 2'd0});
        end
        tick();
        vectors++;
        if (wr_valid !== 1'b0 || busy !== 4'b0000 || drop_cnt !== 16'h1) begin
            miscompares++;
            $display("FAIL bp_end got valid=%b busy=%b drop=%h want 0 0000 0001", wr_valid, busy, drop_cnt);
        end
    endtask

    task automatic test_recapture();
        do_reset();
        wr_ready = 1'b1;
        set_req(1, 8'h21, 3'd1);
        tick();
        req_valid = '0;
        vectors++;
        if (busy !== 4'b0010) begin
            miscompares++;
            $display("FAIL recap_t1 got busy=%b want 0010", busy);
        end
        set_req(1, 8'h20, 3'd6);
        set_req(3, 8'h23, 3'd2);
        tick();
        req_valid = '0;
        vectors++;
        if (wr_word() !== {1'b1, 8'h21, 3'd1, 2'd1} || busy !== 4'b1010 || drop_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL recap_t2 got wr=%h busy=%b drop=%h want wr=%h busy=1010 drop=0000",
                     wr_word(), busy, drop_cnt, {1'b1, 8'h21, 3'd1, 2'd1});
        end
        tick();
        vectors++;
        if (wr_word() !== {1'b1, 8'h23, 3'd2, 2'd3}) begin
            miscompares++;
            $display("FAIL recap_t3 got %h want %h", wr_word(), {1'b1, 8'h23, 3'd2, 2'd3});
        end
        tick();
        vectors++;
        if (wr_word() !== {1'b1, 8'h20, 3'd6, 2'd1}) begin
            miscompares++;
            $display("FAIL recap_t4 got %h want %h", wr_word(), {1'b1, 8'h20, 3'd6, 2'd1});
        end
        tick();
        vectors++;
        if (wr_valid !== 1'b0 || busy !== 4'b0000 || drop_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL recap_end got valid=%b busy=%b drop=%h want 0 0000 0000", wr_valid, busy, drop_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        wr_ready = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, 8'(k), 3'd0);
        tick();
        // slot 0 is granted and recaptures; slots 1..3 each lose a verdict
        for (int k = 0; k < N; k++) set_req(k, 8'(8'h80 + k), 3'd0);
        tick();
        vectors++;
        if (drop_cnt !== 16'd3) begin
            miscompares++;
            $display("FAIL sat_first got %h want 0003", drop_cnt);
        end
        for (int k = 0; k < N; k++) set_req(k, 8'(8'hC0 + k), 3'd0);
        for (int i = 0; i < 16382; i++) tick();
        vectors++;
        if (drop_cnt !== 16'hFFFB || busy !== 4'b1111) begin
            miscompares++;
            $display("FAIL sat_bulk got drop=%h busy=%b want FFFB 1111", drop_cnt, busy);
        end
        req_valid = 4'b0111;
        tick();
        vectors++;
        if (drop_cnt !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL sat_fffe got %h want FFFE", drop_cnt);
        end
        req_valid = 4'b1110;
        tick();
        vectors++;
        if (drop_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_clip got %h want FFFF", drop_cnt);
        end
        req_valid = 4'b1111;
        tick();
        req_valid = '0;
        vectors++;
        if (drop_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_hold got %h want FFFF", drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr_ready = 1'b0;
        set_req(0, 8'h50, 3'd1);
        set_req(1, 8'h51, 3'd2);
        set_req(2, 8'h52, 3'd3);
        tick();
        req_valid = '0;
        tick();
        vectors++;
        if (wr_valid !== 1'b1 || busy !== 4'b0110) begin
            miscompares++;
            $display("FAIL rstmid_setup got valid=%b busy=%b want 1 0110", wr_valid, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (wr_word() !== 14'h0 || busy !== 4'b0000 || drop_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL rstmid_clear got wr=%h busy=%b drop=%h want 0000 0000 0000", wr_word(), busy, drop_cnt);
        end
        // pointer back at 0: slot 0 must win over slot 3
        wr_ready = 1'b1;
        set_req(0, 8'h12, 3'd4);
        set_req(3, 8'h33, 3'd5);
        tick();
        req_valid = '0;
        tick();
        vectors++;
        if (wr_word() !== {1'b1, 8'h12, 3'd4, 2'd0}) begin
            miscompares++;
            $display("FAIL rstmid_ptr got %h want %h", wr_word(), {1'b1, 8'h12, 3'd4, 2'd0});
        end
        tick();
        vectors++;
        if (wr_word() !== {1'b1, 8'h33, 3'd5, 2'd3}) begin
            miscompares++;
            $display("FAIL rstmid_second got %h want %h", wr_word(), {1'b1, 8'h33, 3'd5, 2'd3});
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < N; k++) m_full[k] = 1'b0;
        m_valid = 1'b0;
        m_wid   = '0;
        m_wtype = '0;
        m_src   = 0;
        m_ptr   = 0;
        m_drop  = 0;
    endtask

    // One clock of the arbiter's documented behaviour, from the current inputs.
    task automatic model_step();
        int            g;
        int            nd;
        bit            can_load;
        logic [IW-1:0] id_k;
        logic [TW-1:0] ty_k;
        if (rst) begin
            m_reset();
            return;
        end
        can_load = !m_valid || wr_ready;
        g = -1;
        if (can_load) begin
            for (int off = 0; off < N; off++) begin
                if (g < 0 && m_full[(m_ptr + off) % N]) g = (m_ptr + off) % N;
            end
        end
        if (g >= 0) begin
            m_valid = 1'b1;
            m_wid   = m_id[g];
            m_wtype = m_type[g];
            m_src   = g;
            m_ptr   = (g + 1) % N;
        end else if (can_load) begin
            m_valid = 1'b0;
        end
        nd = 0;
        for (int k = 0; k < N; k++) begin
            id_k = req_id[k*IW +: IW];
            ty_k = req_type[k*TW +: TW];
            if (!req_valid[k]) begin
                if (k == g) m_full[k] = 1'b0;
            end else if (!m_full[k] || k == g) begin
                m_full[k] = 1'b1;
                m_id[k]   = id_k;
                m_type[k] = ty_k;
            end else if (id_k == m_id[k]) begin
                m_type[k] = ty_k;
            end else begin
                nd++;
            end
        end
        m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
    endtask

    task automatic test_random();
        logic [N-1:0] exp_busy;
        do_reset();
        m_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst      = ($urandom_range(0, 249) == 0);
            wr_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                req_valid[k]         = ($urandom_range(0, 9) < 4);
                req_id[k*IW +: IW]   = 8'($urandom_range(0, 3));
                req_type[k*TW +: TW] = 3'($urandom_range(0, 7));
            end
            model_step();
            tick();
            for (int k = 0; k < N; k++) exp_busy[k] = m_full[k];
            vectors++;
            if (wr_word() !== {m_valid, m_wid, m_wtype, 2'(m_src)}) begin
                miscompares++;
                $display("FAIL rand_wr cyc=%0d got %h want %h", cyc, wr_word(),
                         {m_valid, m_wid, m_wtype, 2'(m_src)});
            end
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL rand_busy cyc=%0d got %b want %b", cyc, busy, exp_busy);
            end
            vectors++;
            if (drop_cnt !== 16'(m_drop)) begin
                miscompares++;
                $display("FAIL rand_drop cyc=%0d got %h want %h", cyc, drop_cnt, 16'(m_drop));
            end
        end
        rst       = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_id    = '0;
        req_type  = '0;
        wr_ready  = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_recapture();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
